// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared types for the LSU bus adapter: FSM states, access size codes and result codes.
package ysyx_24110006_lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        SzByte  = 2'd0,
        SzHalf  = 2'd1,
        SzWord  = 2'd2,
        SzDword = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ErrOk       = 2'd0,
        ErrMisalign = 2'd1,
        ErrBus      = 2'd2,
        ErrTimeout  = 2'd3
    } err_e;

    // A dword access is illegal outright on a 32-bit data path.
    function automatic logic misaligned(logic [2:0] addr_lo, size_e size, logic rv32);
        logic bad;
        case (size)
            SzByte:  bad = 1'b0;
            SzHalf:  bad = addr_lo[0];
            SzWord:  bad = |addr_lo[1:0];
            default: bad = rv32 | (|addr_lo);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Lane alignment: load shift plus sign/zero extension, store shift plus byte strobes.
module ysyx_24110006_lsu_align
    import ysyx_24110006_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned StrbW = XLEN / 8,
    localparam int unsigned OffW  = $clog2(StrbW)
) (
    input  logic [OffW-1:0]  offset_i,
    input  size_e            size_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [StrbW-1:0] wstrb_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;
    logic [7:0]      byte_mask;
    logic [15:0]     strb_full;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (size_i)
            SzByte: begin
                mask      = XLEN'(8'hFF);
                sign      = shifted[7];
                byte_mask = 8'h01;
            end
            SzHalf: begin
                mask      = XLEN'(16'hFFFF);
                sign      = shifted[15];
                byte_mask = 8'h03;
            end
            SzWord: begin
                mask      = XLEN'(32'hFFFF_FFFF);
                sign      = shifted[31];
                byte_mask = 8'h0F;
            end
            default: begin
                mask      = '1;
                sign      = shifted[XLEN-1];
                byte_mask = 8'hFF;
            end
        endcase
        load_data_o = (shifted & mask) | ((!unsigned_i && sign) ? ~mask : '0);
        wdata_o     = wdata_i << {offset_i, 3'b000};
        strb_full   = {8'h00, byte_mask} << offset_i;
        wstrb_o     = strb_full[StrbW-1:0];
    end

endmodule

// File: rtl/ysyx_24110006_lsu_bus.sv
// Load/store unit bus adapter: one outstanding access, request/response handshakes,
// misalignment screening and response timeout.
module ysyx_24110006_lsu_bus
    import ysyx_24110006_lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [31:0]       i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_rdata,
    output logic [1:0]        o_err,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [31:0]       o_mem_addr,
    output logic              o_mem_wen,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic              i_mem_rsp_valid,
    output logic              o_mem_rsp_ready,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_rsp_err
);

    localparam int unsigned StrbW     = XLEN / 8;
    localparam int unsigned OffW      = $clog2(StrbW);
    localparam logic [31:0] CntLast   = 32'(TIMEOUT) - 32'd1;
    localparam logic        TimeoutEn = (TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [31:0]       addr_q;
    logic [XLEN-1:0]   wdata_q;
    size_e             size_q;
    logic              uns_q;
    logic              wen_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    err_e              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              capture;
    logic [XLEN-1:0]   load_data;

    ysyx_24110006_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .offset_i    (addr_q[OffW-1:0]),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .rdata_i     (i_mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .wdata_o     (o_mem_wdata),
        .wstrb_o     (o_mem_wstrb)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    capture = 1'b1;
                    if (!i_ren && !i_wen) begin
                        state_d = StDone;
                        rdata_d = '0;
                        err_d   = ErrOk;
                    end else if (misaligned(i_addr[2:0], size_e'(i_size), XLEN == 32)) begin
                        state_d = StDone;
                        rdata_d = '0;
                        err_d   = ErrMisalign;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (i_mem_req_ready) begin
                    state_d = StRsp;
                    cnt_d   = '0;
                end
            end
            StRsp: begin
                if (i_mem_rsp_valid) begin
                    state_d = StDone;
                    rdata_d = wen_q ? '0 : load_data;
                    err_d   = i_mem_rsp_err ? ErrBus : ErrOk;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    // Reaches TIMEOUT on the transition, i.e. after TIMEOUT silent cycles.
                    if (TimeoutEn && cnt_q == CntLast) begin
                        state_d = StDone;
                        rdata_d = '0;
                        err_d   = ErrTimeout;
                    end
                end
            end
            default: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SzByte;
            uns_q   <= 1'b0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= ErrOk;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                size_q  <= size_e'(i_size);
                uns_q   <= i_unsigned;
                wen_q   <= i_wen;
            end
        end
    end

    assign o_ready         = (state_q == StIdle);
    assign o_valid         = (state_q == StDone);
    assign o_rdata         = rdata_q;
    assign o_err           = err_q;
    assign o_mem_req_valid = (state_q == StReq);
    assign o_mem_addr      = {addr_q[31:OffW], {OffW{1'b0}}};
    assign o_mem_wen       = wen_q;
    assign o_mem_rsp_ready = (state_q != StDone);

endmodule

// File: tb/tb_ysyx_24110006_lsu_bus.sv
// Directed bench for the LSU bus adapter (XLEN=32, TIMEOUT=4) with a result scoreboard.
module tb_ysyx_24110006_lsu_bus;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_ren = 1'b0;
    logic        i_wen = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [1:0]  i_size = '0;
    logic        i_unsigned = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_rdata;
    logic [1:0]  o_err;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rsp_valid = 1'b0;
    logic        o_mem_rsp_ready;
    logic [31:0] i_mem_rdata = '0;
    logic        i_mem_rsp_err = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   last_wait = 0;

    always #5 clk = ~clk;

    ysyx_24110006_lsu_bus #(
        .XLEN    (32),
        .TIMEOUT (4)
    ) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_ren           (i_ren),
        .i_wen           (i_wen),
        .i_addr          (i_addr),
        .i_wdata         (i_wdata),
        .i_size          (i_size),
        .i_unsigned      (i_unsigned),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_rdata         (o_rdata),
        .o_err           (o_err),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wen       (o_mem_wen),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_wstrb     (o_mem_wstrb),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .o_mem_rsp_ready (o_mem_rsp_ready),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_rsp_err   (i_mem_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after acceptance.
    task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        exp_t e;
        check("accept_ready", o_ready, 1);
        i_valid = 1'b1;
        i_ren = ren;
        i_wen = wen;
        i_addr = addr;
        i_wdata = wdata;
        i_size = size;
        i_unsigned = uns;
        @(negedge clk);
        i_valid = 1'b0;
        e.rdata = exp_rdata;
        e.err = exp_err;
        exp_q.push_back(e);
    endtask

    // Plays the memory side: stalls the request, then responds in the first RSP cycle.
    task automatic mem_serve(input int req_wait, input logic [31:0] exp_addr,
                             input logic exp_wen, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input logic [31:0] rd,
                             input logic rerr);
        for (int i = 0; i <= req_wait; i++) begin
            check("req_valid", o_mem_req_valid, 1);
            check("req_addr", o_mem_addr, exp_addr);
            check("req_wen", o_mem_wen, exp_wen);
            if (exp_wen) begin
                check("req_wdata", o_mem_wdata, exp_wdata);
                check("req_wstrb", o_mem_wstrb, exp_wstrb);
            end
            i_mem_req_ready = (i == req_wait);
            @(negedge clk);
        end
        i_mem_req_ready = 1'b0;
        check("req_drop", o_mem_req_valid, 0);
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata = rd;
        i_mem_rsp_err = rerr;
        @(negedge clk);
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_err = 1'b0;
    endtask

    // Waits (bounded) for a result, scores it, stalls writeback for `hold` cycles.
    task automatic collect(input int hold);
        int   waited = 0;
        exp_t e;
        while (o_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        check("res_valid", o_valid, 1);
        n_assert++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_rdata", o_rdata, e.rdata);
            check("res_err", o_err, e.err);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", o_valid, 1);
                check("hold_rdata", o_rdata, e.rdata);
                check("hold_err", o_err, e.err);
                check("hold_ready", o_ready, 0);
            end
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("ret_valid", o_valid, 0);
        check("ret_ready", o_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_req_valid", o_mem_req_valid, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_err", o_err, 0);
        check("rst_rsp_ready", o_mem_rsp_ready, 1);

        // lb at 0x1003, zero-wait memory; result appears in the 3rd cycle after accept.
        issue(1, 0, 32'h1003, 0, 2'd0, 0, 32'hFFFF_FF80, 2'd0);
        check("lb_early", o_valid, 0);
        mem_serve(0, 32'h1000, 0, 0, 0, 32'h80FF_FF00, 0);
        collect(0);
        check("lb_latency", last_wait, 0);

        issue(1, 0, 32'h1003, 0, 2'd0, 1, 32'h0000_0080, 2'd0);
        mem_serve(0, 32'h1000, 0, 0, 0, 32'h80FF_FF00, 0);
        collect(0);
        issue(1, 0, 32'h1002, 0, 2'd1, 0, 32'hFFFF_8001, 2'd0);
        mem_serve(0, 32'h1000, 0, 0, 0, 32'h8001_1234, 0);
        collect(0);
        issue(1, 0, 32'h1002, 0, 2'd1, 1, 32'h0000_8001, 2'd0);
        mem_serve(0, 32'h1000, 0, 0, 0, 32'h8001_1234, 0);
        collect(0);
        issue(1, 0, 32'h1004, 0, 2'd2, 0, 32'h1234_5678, 2'd0);
        mem_serve(0, 32'h1004, 0, 0, 0, 32'h1234_5678, 0);
        collect(0);
        issue(1, 0, 32'h1001, 0, 2'd0, 0, 32'h0000_007F, 2'd0);
        mem_serve(0, 32'h1000, 0, 0, 0, 32'h0000_7F00, 0);
        collect(0);

        // Stores return rdata 0; writeback stalls 3 cycles on the sh.
        issue(0, 1, 32'h1002, 32'h0000_ABCD, 2'd1, 0, 32'h0, 2'd0);
        mem_serve(0, 32'h1000, 1, 32'hABCD_0000, 4'b1100, 32'hDEAD_BEEF, 0);
        collect(3);
        issue(0, 1, 32'h1001, 32'h0000_005A, 2'd0, 0, 32'h0, 2'd0);
        mem_serve(0, 32'h1000, 1, 32'h0000_5A00, 4'b0010, 32'hDEAD_BEEF, 0);
        collect(0);
        issue(1, 1, 32'h1004, 32'hCAFE_F00D, 2'd2, 0, 32'h0, 2'd0);
        mem_serve(0, 32'h1004, 1, 32'hCAFE_F00D, 4'b1111, 32'hDEAD_BEEF, 0);
        collect(0);

        // Screened requests never reach the bus.
        issue(1, 0, 32'h1001, 0, 2'd2, 0, 32'h0, 2'd1);
        check("mis_no_bus", o_mem_req_valid, 0);
        collect(0);
        issue(1, 0, 32'h1000, 0, 2'd3, 0, 32'h0, 2'd1);
        check("dw_no_bus", o_mem_req_valid, 0);
        collect(0);
        issue(0, 0, 32'h1000, 32'hFFFF_FFFF, 2'd2, 0, 32'h0, 2'd0);
        check("nop_no_bus", o_mem_req_valid, 0);
        collect(0);

        // Request stalled 5 cycles, then a faulting response.
        issue(1, 0, 32'h2000, 0, 2'd2, 0, 32'h1122_3344, 2'd2);
        mem_serve(5, 32'h2000, 0, 0, 0, 32'h1122_3344, 1);
        collect(0);

        // Timeout: four silent RSP cycles, then err 3.
        issue(1, 0, 32'h3000, 0, 2'd2, 0, 32'h0, 2'd3);
        check("to_req_valid", o_mem_req_valid, 1);
        i_mem_req_ready = 1'b1;
        @(negedge clk);
        i_mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_early", o_valid, 0);
            @(negedge clk);
        end
        collect(0);
        check("to_latency", last_wait, 0);
        // Late response lands in IDLE and must vanish.
        check("stale_rsp_ready", o_mem_rsp_ready, 1);
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        i_mem_rsp_valid = 1'b0;
        check("stale_valid", o_valid, 0);
        check("stale_ready", o_ready, 1);
        issue(1, 0, 32'h3000, 0, 2'd2, 0, 32'h0BAD_F00D, 2'd0);
        mem_serve(0, 32'h3000, 0, 0, 0, 32'h0BAD_F00D, 0);
        collect(0);

        // Reset while the request is pending.
        issue(1, 0, 32'h4000, 0, 2'd2, 0, 32'h0, 2'd0);
        check("rreq_valid", o_mem_req_valid, 1);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        exp_q.delete();
        check("rreq_drop", o_mem_req_valid, 0);
        check("rreq_ready", o_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("rreq_no_valid", o_valid, 0);
            @(negedge clk);
        end
        check("rreq_idle_req", o_mem_req_valid, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
